// File: rtl/io_input_capture.sv
// Memory-mapped KEY/SW input peripheral: 2-FF synchronizers, per-bit debouncers,
// sticky write-1-to-clear key press register and a combinational read port.
module io_input_capture #(
  parameter int N_KEYS    = 4,
  parameter int N_SW      = 10,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_SW-1:0]   sw,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  input  logic              memwrite,
  output logic [31:0]       io_readdata,
  output logic              key_event
);

  localparam int N_BITS = N_KEYS + N_SW;
  localparam int CW     = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N_KEYS-1:0] key_s1_reg, key_s2_reg;
  logic [N_SW-1:0]   sw_s1_reg, sw_s2_reg;
  logic [N_BITS-1:0] raw, state_reg, state_next;
  logic [CW-1:0]     cnt_reg  [N_BITS];
  logic [CW-1:0]     cnt_next [N_BITS];
  logic [N_KEYS-1:0] key_state, key_edge_reg, key_edge_next, edge_set, edge_clr;
  logic [N_SW-1:0]   sw_state;
  logic              key_event_reg;
  logic              io, sel_state, sel_edge, sel_sw;
  logic              unused_bits;

  // Keys idle high at the pin, so their synchronizers reset to "released".
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_reg <= '1;
      key_s2_reg <= '1;
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
    end else begin
      key_s1_reg <= key_n;
      key_s2_reg <= key_s1_reg;
      sw_s1_reg  <= sw;
      sw_s2_reg  <= sw_s1_reg;
    end
  end

  // Keys and switches share one debounce vector; keys sit in the low bits, 1 = pressed.
  assign raw = {sw_s2_reg, ~key_s2_reg};

  genvar gi;
  generate
    for (gi = 0; gi < N_BITS; gi++) begin : g_db
      assign state_next[gi] = (raw[gi] != state_reg[gi] && cnt_reg[gi] == CNT_LAST)
                              ? raw[gi] : state_reg[gi];
      assign cnt_next[gi]   = (raw[gi] == state_reg[gi] || cnt_reg[gi] == CNT_LAST)
                              ? '0 : cnt_reg[gi] + CW'(1);

      always_ff @(posedge clk) begin
        if (reset) cnt_reg[gi] <= '0;
        else       cnt_reg[gi] <= cnt_next[gi];
      end
    end
  endgenerate

  assign key_state = state_reg[N_KEYS-1:0];
  assign sw_state  = state_reg[N_BITS-1:N_KEYS];

  assign io        = addr[8];
  assign sel_state = io & addr[4] & ~addr[2];
  assign sel_edge  = io & addr[4] &  addr[2];
  assign sel_sw    = io & addr[5] & ~addr[4];

  // A press landing on the same clock as its clear must survive.
  assign edge_set      = state_next[N_KEYS-1:0] & ~key_state;
  assign edge_clr      = {N_KEYS{memwrite & sel_edge}} & writedata[N_KEYS-1:0];
  assign key_edge_next = edge_set | (key_edge_reg & ~edge_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= '0;
      key_edge_reg  <= '0;
      key_event_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_edge_reg  <= key_edge_next;
      key_event_reg <= |key_edge_next;
    end
  end

  assign key_event = key_event_reg;

  always_comb begin
    io_readdata = '0;
    if (sel_state)     io_readdata[N_KEYS-1:0] = key_state;
    else if (sel_edge) io_readdata[N_KEYS-1:0] = key_edge_reg;
    else if (sel_sw)   io_readdata[N_SW-1:0]   = sw_state;
  end

  assign unused_bits = ^{addr[31:9], addr[7:6], addr[3], addr[1:0], writedata[31:N_KEYS]};

endmodule

// File: tb/tb_io_input_capture.sv
// Directed bench for io_input_capture: expectations queued on a scoreboard as
// stimulus is applied, popped and compared when the DUT output is sampled.
module tb_io_input_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [31:0] addr, writedata;
  logic        memwrite;
  logic [31:0] io_readdata;
  logic        key_event;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  io_input_capture #(.N_KEYS(4), .N_SW(10), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw), .addr(addr),
    .writedata(writedata), .memwrite(memwrite), .io_readdata(io_readdata),
    .key_event(key_event)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a;
    #1;
    check(io_readdata);
  endtask

  task automatic ev();
    #1;
    check({31'b0, key_event});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    tick(1);
    memwrite  = 1'b0;
    writedata = '0;
  endtask

  initial begin
    reset = 1'b1; key_n = 4'hF; sw = '0; addr = '0; writedata = '0; memwrite = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    push("rst_key_state", 32'h0); rd(32'h110);
    push("rst_key_edge",  32'h0); rd(32'h114);
    push("rst_sw_state",  32'h0); rd(32'h120);
    push("rst_key_event", 32'h0); ev();

    // Key 0 press: visible exactly 6 clocks after the pin edge
    key_n[0] = 1'b0;
    push("k0_state_clk5", 32'h0); push("k0_state_clk6", 32'h1);
    push("k0_edge_clk6", 32'h1);  push("k0_event_clk6", 32'h1);
    tick(5); rd(32'h110);
    tick(1); rd(32'h110); rd(32'h114); ev();

    // 3-cycle glitch on key 1 is rejected
    key_n[1] = 1'b0; tick(3); key_n[1] = 1'b1;
    push("glitch3_state", 32'h1); push("glitch3_edge", 32'h1);
    tick(10); rd(32'h110); rd(32'h114);

    // 4-cycle pulse on key 1 is accepted
    key_n[1] = 1'b0; tick(4); key_n[1] = 1'b1;
    push("pulse4_state_on", 32'h3);
    tick(2); rd(32'h110);
    push("pulse4_state_off", 32'h1); push("pulse4_edge", 32'h3);
    tick(10); rd(32'h110); rd(32'h114);

    // Write-1-to-clear and ignored writes
    push("w1c_bit0", 32'h2); push("w1c_bit0_event", 32'h1);
    store(32'h114, 32'h1); rd(32'h114); ev();
    push("io0_write_ignored", 32'h2);
    store(32'h014, 32'hFFFF_FFFF); rd(32'h114);
    push("state_write_ignored", 32'h1);
    store(32'h110, 32'hFFFF_FFFF); rd(32'h110);
    push("upper_wdata_ignored", 32'h2);
    store(32'h114, 32'hFFFF_FFF0); rd(32'h114);
    push("w1c_all", 32'h0); push("w1c_all_event", 32'h0);
    store(32'h114, 32'hFFFF_FFFF); rd(32'h114); ev();

    // Set beats clear on the same clock
    key_n[2] = 1'b0;
    push("setclr_before", 32'h0); push("setclr_edge", 32'h4); push("setclr_event", 32'h1);
    tick(5); rd(32'h114);
    store(32'h114, 32'h4);
    rd(32'h114); ev();

    // Releases are not captured
    key_n = 4'hF;
    push("release_state", 32'h0); push("release_edge", 32'h0); push("release_event", 32'h0);
    store(32'h114, 32'hF);
    tick(10); rd(32'h110); rd(32'h114); ev();

    // Switches debounce with the same latency, never touch key_edge
    sw = 10'h2A5;
    push("sw_clk5", 32'h0); push("sw_clk6", 32'h2A5); push("sw_edge", 32'h0);
    push("sw_io0_read", 32'h0); push("io_unmapped_read", 32'h0);
    tick(5); rd(32'h120);
    tick(1); rd(32'h120); rd(32'h114); rd(32'h020);
    addr = 32'h100; #1; check(io_readdata);

    // Reset mid-debounce discards the count, then the switch re-debounces
    sw = 10'h15A;
    tick(3);
    reset = 1'b1; tick(1); reset = 1'b0;
    push("sw_after_reset", 32'h0);
    push("sw_redb_clk5", 32'h0); push("sw_redb_clk6", 32'h15A);
    rd(32'h120);
    tick(5); rd(32'h120);
    tick(1); rd(32'h120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
